// File: rtl/multdiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds FSM state encoding, iteration counts and the radix-4 Booth recoding table.
package multdiv_unit_pkg;

   localparam int MULT_ITERS = 16;
   localparam int DIV_ITERS  = 32;
   localparam int CNT_W      = 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      BOOTH_ZERO,
      BOOTH_PM,
      BOOTH_P2M,
      BOOTH_MM,
      BOOTH_M2M
   } booth_op_e;

   // Bits are {q[i+1], q[i], q[i-1]} of the multiplier.
   function automatic booth_op_e booth_decode(input logic [2:0] bits);
      booth_op_e op;
      case (bits)
         3'b001, 3'b010: op = BOOTH_PM;
         3'b011:         op = BOOTH_P2M;
         3'b100:         op = BOOTH_M2M;
         3'b101, 3'b110: op = BOOTH_MM;
         default:        op = BOOTH_ZERO;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/multdiv_unit_booth_select.sv
// Maps three multiplier bits to a sign-extended radix-4 partial product.
// Produces 0, +M, +2M, -M or -2M; two extra bits cover the +/-2M range.
module booth_select
   import multdiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic [2:0]       bits_i,
   input  logic [WIDTH-1:0] mcand_i,
   output logic [WIDTH+1:0] pp_o
);

   localparam logic [WIDTH+1:0] ONE_PP = 1;

   booth_op_e        op;
   logic [WIDTH+1:0] m1;
   logic [WIDTH+1:0] m2;

   always_comb begin
      op = booth_decode(bits_i);
      m1 = {{2{mcand_i[WIDTH-1]}}, mcand_i};
      m2 = {mcand_i[WIDTH-1], mcand_i, 1'b0};
      pp_o = '0;
      case (op)
         BOOTH_PM:  pp_o = m1;
         BOOTH_P2M: pp_o = m2;
         BOOTH_MM:  pp_o = ~m1 + ONE_PP;
         BOOTH_M2M: pp_o = ~m2 + ONE_PP;
         default:   pp_o = '0;
      endcase
   end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (radix-4 Booth, 16 steps) / divide (non-restoring, 32 steps).
// Fixed latency: result pulse 17 (MULT) or 33 (DIV) edges after the start edge.
module multdiv_unit
   import multdiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam int               AW        = 2*WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_ITERS - 1);
   localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_ITERS - 1);
   localparam logic [WIDTH-1:0] ONE_W     = 1;
   localparam logic [WIDTH-1:0] MIN_W     = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic             neg_q, neg_d;
   logic             dbz_q, dbz_d;
   logic             dovf_q, dovf_d;
   logic             op_div_q, op_div_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             exc_q, exc_d;
   logic             rdy_q, rdy_d;

   logic [WIDTH+1:0] pp;
   logic [WIDTH+1:0] booth_sum;
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH:0]   prod_hi;

   booth_select #(.WIDTH(WIDTH)) u_booth (
      .bits_i  (acc_q[2:0]),
      .mcand_i (mcand_q),
      .pp_o    (pp)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvsr_d   = dvsr_q;
      neg_d    = neg_q;
      dbz_d    = dbz_q;
      dovf_d   = dovf_q;
      op_div_d = op_div_q;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;

      // Add the partial product into the upper half, then arithmetic-shift by two.
      booth_sum = {{2{acc_q[AW-1]}}, acc_q[AW-1:WIDTH+1]} + pp;
      rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      rem_next  = rem_q[WIDTH] ? rem_shift + {1'b0, dvsr_q}
                               : rem_shift - {1'b0, dvsr_q};
      prod_hi   = acc_q[2*WIDTH:WIDTH];

      case (state_q)
         S_MULT: begin
            acc_d = {booth_sum, acc_q[WIDTH:2]};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == MULT_LAST) state_d = S_DONE;
         end
         S_DIV: begin
            rem_d = rem_next;
            quo_d = {quo_q[WIDTH-2:0], ~rem_next[WIDTH]};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == DIV_LAST) state_d = S_DONE;
         end
         S_DONE: begin
            rdy_d   = 1'b1;
            state_d = S_IDLE;
            if (op_div_q) begin
               exc_d = dbz_q | dovf_q;
               if (dbz_q)      result_d = '0;
               else if (neg_q) result_d = ~quo_q + ONE_W;
               else            result_d = quo_q;
            end else begin
               result_d = acc_q[WIDTH:1];
               exc_d    = ~((&prod_hi) | ~(|prod_hi));
            end
         end
         default: ;
      endcase

      // A new start always wins, discarding whatever was in flight (including DONE).
      if (ctrl_MULT || ctrl_DIV) begin
         state_d  = ctrl_MULT ? S_MULT : S_DIV;
         op_div_d = ~ctrl_MULT;
         cnt_d    = '0;
         rdy_d    = 1'b0;
         result_d = result_q;
         exc_d    = exc_q;
         acc_d    = {{WIDTH{1'b0}}, data_operandB, 1'b0};
         mcand_d  = data_operandA;
         rem_d    = '0;
         quo_d    = data_operandA[WIDTH-1] ? ~data_operandA + ONE_W : data_operandA;
         dvsr_d   = data_operandB[WIDTH-1] ? ~data_operandB + ONE_W : data_operandB;
         neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         dbz_d    = (data_operandB == '0);
         dovf_d   = (data_operandA == MIN_W) && (&data_operandB);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dvsr_q   <= '0;
         neg_q    <= 1'b0;
         dbz_q    <= 1'b0;
         dovf_q   <= 1'b0;
         op_div_q <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dvsr_q   <= dvsr_d;
         neg_q    <= neg_d;
         dbz_q    <= dbz_d;
         dovf_q   <= dovf_d;
         op_div_q <= op_div_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random bench for multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;

   int checks = 0;
   int errors = 0;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void ref_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic e);
      longint p;
      int     sa, sb;
      if (!is_div) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p != longint'($signed(p[31:0])));
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         sa = a;
         sb = b;
         r  = sa / sb;
         e  = 1'b0;
      end
   endfunction

   // kind: 0 = MULT, 1 = DIV, 2 = both strobes (multiply expected)
   task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] er;
      logic        ee;
      int          k;
      ref_model(kind == 1, a, b, er, ee);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = (kind != 1);
      ctrl_DIV      = (kind != 0);
      @(posedge clock); #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      k = 0;
      while (!data_resultRDY && k < 100) begin
         @(posedge clock); #1;
         k++;
      end
      chk({tag, " latency"}, 32'(k), (kind == 1) ? 32'd33 : 32'd17);
      chk({tag, " result"}, data_result, er);
      chk({tag, " exc"}, {31'd0, data_exception}, {31'd0, ee});
   endtask

   function automatic logic [31:0] rnd_operand();
      case ($urandom_range(0, 5))
         0:       return 32'($urandom_range(0, 20)) - 32'd10;
         1:       return 32'($urandom_range(0, 70000)) - 32'd35000;
         2:       return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 1));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          k;
      int          rdy_cnt;
      int          lat;
      logic [31:0] res;
      logic [31:0] held;

      reset = 1'b1;
      data_operandA = '0;
      data_operandB = '0;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      #1;
      chk("reset result", data_result, 32'd0);
      chk("reset exc", {31'd0, data_exception}, 32'd0);
      chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock); #1;

      do_op(0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3");
      held = data_result;
      repeat (3) @(posedge clock);
      #1;
      chk("hold result", data_result, held);
      chk("hold rdy low", {31'd0, data_resultRDY}, 32'd0);
      do_op(0, 32'h0001_0000, 32'h0001_0000, "mul ovf 2^32");
      do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, "mul min*-1");
      do_op(0, 32'd0, 32'hDEAD_BEEF, "mul 0*x");
      do_op(2, 32'd123, 32'hFFFF_FF00, "both strobes");
      do_op(1, 32'hFFFF_FF9C, 32'd7, "div -100/7");
      do_op(1, 32'd100, 32'hFFFF_FFF9, "div 100/-7");
      do_op(1, 32'd5, 32'd0, "div by zero");
      do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
      do_op(1, 32'h1234_5678, 32'd1, "div x/1");
      do_op(1, 32'd0, 32'hFFFF_FFF7, "div 0/x");
      do_op(1, 32'h8000_0000, 32'd1, "div min/1");

      // Divide preempted by a multiply launched at edge 10.
      data_operandA = 32'd1000;
      data_operandB = 32'd3;
      ctrl_DIV = 1'b1;
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      rdy_cnt = 0;
      lat = -1;
      res = 'x;
      repeat (9) begin
         @(posedge clock); #1;
         if (data_resultRDY) rdy_cnt++;
      end
      data_operandA = 32'd6;
      data_operandB = 32'd7;
      ctrl_MULT = 1'b1;
      @(posedge clock); #1;
      ctrl_MULT = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clock); #1;
         if (data_resultRDY) begin
            rdy_cnt++;
            if (lat < 0) begin
               lat = i;
               res = data_result;
            end
         end
      end
      chk("preempt rdy count", 32'(rdy_cnt), 32'd1);
      chk("preempt latency", 32'(lat), 32'd17);
      chk("preempt result", res, 32'd42);

      // Reset in the middle of a divide.
      data_operandA = 32'd1000;
      data_operandB = 32'd3;
      ctrl_DIV = 1'b1;
      @(posedge clock); #1;
      ctrl_DIV = 1'b0;
      repeat (19) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("midreset result", data_result, 32'd0);
      chk("midreset exc", {31'd0, data_exception}, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      rdy_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clock); #1;
         if (data_resultRDY) rdy_cnt++;
      end
      chk("midreset no rdy", 32'(rdy_cnt), 32'd0);
      chk("midreset result held", data_result, 32'd0);

      for (int n = 0; n < 1000; n++) begin
         k = $urandom_range(0, 1);
         do_op(k, rnd_operand(), rnd_operand(), (k == 1) ? "rand div" : "rand mul");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
